// File: rtl/seg7_mmio.sv
// Memory-mapped multiplexed 7-segment driver: DATA/CTRL registers, scan prescaler, hex decode; SEG7_BLINK_EN adds per-digit blink.
// Register writes are single-cycle; reads are combinational; display outputs are registered one cycle behind state; no backpressure.
module seg7_mmio #(
  parameter int          DIGITS    = 4,
  parameter int          SCAN_DIV  = 50000,
  parameter logic [63:0] BASE_ADDR = 64'h1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       addr,
  input  logic [63:0]       wdata,
  input  logic [1:0]        word,
  input  logic              rw,
  output logic [63:0]       rdata,
  output logic [6:0]        seg_out,
  output logic              seg_dp,
  output logic [DIGITS-1:0] seg_sel
);

  localparam int          DW         = 4 * DIGITS;
  localparam int          PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]  IDX_LAST   = 3'(DIGITS - 1);
  localparam logic [63:0] CTRL_ADDR  = BASE_ADDR + 64'd8;
`ifdef SEG7_BLINK_EN
  localparam logic [31:0] CTRL_WMASK = 32'h00FF_FF01;
`else
  localparam logic [31:0] CTRL_WMASK = 32'h0000_FF01;
`endif

  logic [DW-1:0]   data_r;
  logic [31:0]     ctrl_r;
  logic [PW-1:0]   presc;
  logic [2:0]      idx;
  logic            tick;
  logic            hit_data;
  logic            hit_ctrl;
  logic [63:0]     wmask;
  logic [3:0]      nib;
  logic [7:0]      dp_mask;
  logic            blink_hide;
  logic [DIGITS-1:0] sel_nx;
  logic [6:0]      out_nx;
  logic            dp_nx;

  assign hit_data = (addr == BASE_ADDR);
  assign hit_ctrl = (addr == CTRL_ADDR);
  assign tick     = (presc == PRESC_LAST);

  always_comb begin
    wmask = 64'hFF;
    case (word)
      2'b00:   wmask = 64'h0000_0000_0000_00FF;
      2'b01:   wmask = 64'h0000_0000_0000_FFFF;
      2'b10:   wmask = 64'h0000_0000_FFFF_FFFF;
      default: wmask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  // Merge only the accessed low bytes; bits above the register width fall off in the cast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
      ctrl_r <= '0;
    end else if (rw) begin
      if (hit_data)
        data_r <= DW'((64'(data_r) & ~wmask) | (wdata & wmask));
      if (hit_ctrl)
        ctrl_r <= 32'((64'(ctrl_r) & ~wmask) | (wdata & wmask)) & CTRL_WMASK;
    end
  end

  always_comb begin
    rdata = '0;
    if (!rw) begin
      if (hit_data)
        rdata = 64'(data_r);
      else if (hit_ctrl)
        rdata = 64'(ctrl_r);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick)
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end
  end

`ifdef SEG7_BLINK_EN
  logic [5:0] wrap_cnt;
  logic       blink_phase;
  logic [7:0] blink_mask;

  // Phase flips on every 64th wrap of the digit index back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_cnt    <= '0;
      blink_phase <= 1'b0;
    end else if (tick && idx == IDX_LAST) begin
      wrap_cnt <= wrap_cnt + 6'd1;
      if (wrap_cnt == 6'd63)
        blink_phase <= ~blink_phase;
    end
  end

  assign blink_mask = ctrl_r[23:16];
  assign blink_hide = blink_phase & blink_mask[idx];
`else
  assign blink_hide = 1'b0;
`endif

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign nib     = 4'(data_r >> {idx, 2'b00});
  assign dp_mask = ctrl_r[15:8];

  always_comb begin
    sel_nx = '1;
    out_nx = 7'h7F;
    dp_nx  = 1'b1;
    if (ctrl_r[0] && !blink_hide) begin
      sel_nx = ~(DIGITS'(1) << idx);
      out_nx = ~hex_seg(nib);
      dp_nx  = ~dp_mask[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_sel <= '1;
      seg_out <= 7'h7F;
      seg_dp  <= 1'b1;
    end else begin
      seg_sel <= sel_nx;
      seg_out <= out_nx;
      seg_dp  <= dp_nx;
    end
  end

endmodule

// File: tb/tb_seg7_mmio.sv
// Scoreboard bench for seg7_mmio: a cycle-count reference model predicts display outputs and read data.
module tb_seg7_mmio;

  localparam int          D    = 4;
  localparam int          S    = 4;
  localparam logic [63:0] BASE = 64'h1024;
`ifdef SEG7_BLINK_EN
  localparam logic [31:0] CW = 32'h00FF_FF01;
  localparam bit          BLINK = 1'b1;
`else
  localparam logic [31:0] CW = 32'h0000_FF01;
  localparam bit          BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  word;
  logic        rw;
  logic [63:0] rdata;
  logic [6:0]  seg_out;
  logic        seg_dp;
  logic [D-1:0] seg_sel;

  seg7_mmio #(.DIGITS(D), .SCAN_DIV(S), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .word(word), .rw(rw),
    .rdata(rdata), .seg_out(seg_out), .seg_dp(seg_dp), .seg_sel(seg_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [D-1:0] sel;
    logic [6:0]   out;
    logic         dp;
  } disp_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] exp;
  } rd_t;

  int errors = 0;
  int checks = 0;

  disp_t exp_q[$];
  rd_t   rd_q[$];

  // Reference state: cycles since reset release plus register images.
  int          k = 0;
  logic [63:0] mdata = '0;
  logic [31:0] mctrl = '0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic disp_t blank();
    disp_t b;
    b.sel = '1;
    b.out = 7'h7F;
    b.dp  = 1'b1;
    return b;
  endfunction

  function automatic disp_t predict(int kk, logic [63:0] dat, logic [31:0] ctl);
    disp_t e;
    int    di;
    int    wraps;
    bit    phase;
    int    nb;
    di    = (kk / S) % D;
    wraps = (kk / S) / D;
    phase = BLINK && (((wraps / 64) % 2) == 1);
    if (!ctl[0] || (phase && ctl[16 + di]))
      return blank();
    nb    = int'((dat >> (4 * di)) & 64'hF);
    e.sel = ~(D'(1) << di);
    e.out = ~hex_tab[nb];
    e.dp  = ~ctl[8 + di];
    return e;
  endfunction

  function automatic logic [63:0] size_mask(logic [1:0] w);
    int bits;
    bits = 8 << w;
    if (bits >= 64)
      return '1;
    return (64'd1 << bits) - 64'd1;
  endfunction

  function automatic logic [63:0] expected_read(logic [63:0] a);
    if (a == BASE)
      return mdata;
    if (a == BASE + 64'd8)
      return 64'(mctrl);
    return '0;
  endfunction

  // Model: expected output after each edge follows from the state before that edge.
  initial forever begin
    logic [63:0] m;
    @(posedge clk);
    if (rst) begin
      k     = 0;
      mdata = '0;
      mctrl = '0;
      exp_q.push_back(blank());
    end else begin
      exp_q.push_back(predict(k, mdata, mctrl));
      if (rw) begin
        m = size_mask(word);
        if (addr == BASE)
          mdata = ((mdata & ~m) | (wdata & m)) & 64'hFFFF;
        else if (addr == BASE + 64'd8)
          mctrl = 32'((64'(mctrl) & ~m) | (wdata & m)) & CW;
      end
      k++;
    end
  end

  // Monitor: pops expectations and compares against what the DUT presents.
  initial forever begin
    disp_t e;
    rd_t   r;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (seg_sel !== e.sel || seg_out !== e.out || seg_dp !== e.dp) begin
        errors++;
        $display("FAIL disp t=%0t: got sel=%b out=%h dp=%b, want sel=%b out=%h dp=%b",
                 $time, seg_sel, seg_out, seg_dp, e.sel, e.out, e.dp);
      end
    end
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      checks++;
      if (rdata !== r.exp) begin
        errors++;
        $display("FAIL read addr=%h: got %h, want %h", r.a, rdata, r.exp);
      end
    end
  end

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rw   = 1'b0;
      addr = '0;
    end
  endtask

  task automatic do_write(logic [63:0] a, logic [1:0] w, logic [63:0] d);
    @(posedge clk); #1;
    rw    = 1'b1;
    addr  = a;
    word  = w;
    wdata = d;
  endtask

  task automatic do_read(logic [63:0] a);
    rd_t r;
    @(posedge clk); #1;
    rw    = 1'b0;
    addr  = a;
    word  = 2'($urandom_range(0, 3));
    wdata = {$urandom, $urandom};
    r.a   = a;
    r.exp = expected_read(a);
    rd_q.push_back(r);
  endtask

  task automatic check_blank_now(string name);
    checks++;
    if (seg_sel !== '1 || seg_out !== 7'h7F || seg_dp !== 1'b1) begin
      errors++;
      $display("FAIL %s: got sel=%b out=%h dp=%b, want all ones", name, seg_sel, seg_out, seg_dp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b1; rw = 1'b0; addr = '0; wdata = '0; word = 2'b00;
    idle(2);
    check_blank_now("reset_blank");
    do_read(BASE + 64'd8);
    do_read(BASE);
    idle(1);
    rst = 1'b0;

    // Half write and scan cycle F, A, 2, 1.
    idle(3);
    do_write(BASE, 2'b01, 64'h0000_0000_0000_12AF);
    do_write(BASE + 64'd8, 2'b10, 64'h1);
    idle(40);
    do_read(BASE);
    do_read(BASE + 64'd8);

    // Size-limited writes.
    do_write(BASE, 2'b01, 64'h1234);
    do_write(BASE, 2'b00, 64'hFFFF_FFFF_FFFF_FF5C);
    do_read(BASE);
    do_write(BASE, 2'b11, 64'hFFFF_0000_0000_0009);
    do_read(BASE);

    // Decimal points, then disable mid-scan.
    do_write(BASE, 2'b01, 64'h8E3D);
    do_write(BASE + 64'd8, 2'b10, 64'h0000_0501);
    idle(22);
    do_write(BASE + 64'd8, 2'b10, 64'h0);
    idle(6);
    do_write(BASE + 64'd8, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read(BASE + 64'd8);
    do_write(BASE + 64'd8, 2'b00, 64'h01);
    idle(10);

    // Random traffic to register and unmapped addresses.
    for (int n = 0; n < 300; n++) begin
      logic [63:0] a;
      case ($urandom_range(0, 3))
        0: a = BASE;
        1: a = BASE + 64'd8;
        2: a = BASE + 64'd4;
        default: a = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(a, 2'($urandom_range(0, 3)), {$urandom, $urandom});
      else
        do_read(a);
      idle($urandom_range(0, 2));
    end

    // Async reset during dwell of digit 2.
    do_write(BASE, 2'b01, 64'h7654);
    do_write(BASE + 64'd8, 2'b10, 64'h0000_0401);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(posedge clk); #1;
      rw = 1'b0;
      if (((k / S) % D) == 2 && (k % S) == 1)
        found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_digit2: got no dwell of digit 2 within 100 cycles, want one");
    end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_blank_now("async_reset_blank");
    idle(3);
    rst = 1'b0;
    do_read(BASE);
    do_write(BASE + 64'd8, 2'b00, 64'h01);
    idle(20);

    // Blink on digit 1 across two phase periods.
    do_write(BASE, 2'b01, 64'h4321);
    do_write(BASE + 64'd8, 2'b10, 64'h0002_0001);
    idle(64 * S * D * 2 + 40);
    do_read(BASE + 64'd8);
    idle(4);

    checks++;
    if (exp_q.size() > 2 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, want at most 2/0", exp_q.size(), rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
